// File: rtl/lsu_writeback.sv
// Memory/writeback stage of the 3-stage RV32I core.
// Accepts one executed instruction at a time from EX. Loads and stores run a
// req/ack handshake with data memory. Load data is aligned and extended before
// the register-file write. Non-memory results reach the register file one cycle
// after acceptance, and can be accepted back to back.
module lsu_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_is_load,
    input  logic                      ex_is_store,
    input  logic [2:0]                ex_funct3,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [ADDR_WIDTH-1:0]     ex_rd,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      rf_wen,
    output logic [ADDR_WIDTH-1:0]     rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      fault_valid,
    output logic [1:0]                fault_code
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    // Counter only has to reach TIMEOUT-1; keep at least one bit when TIMEOUT is 0 or 1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Context of the access in flight, held while the request is outstanding.
    logic                  req_load_reg;
    logic [2:0]            req_funct3_reg;
    logic [1:0]            req_off_reg;
    logic [ADDR_WIDTH-1:0] req_rd_reg;
    logic [CNT_W-1:0]      timer_reg;

    logic       accept;
    logic       is_mem;
    logic       illegal_width;
    logic       misaligned;
    logic       mem_start;
    logic       mem_fault;
    logic       req_timeout;
    logic [1:0] size;

    logic [DATA_WIDTH-1:0] st_wdata;
    logic [NUM_LANES-1:0]  st_wstrb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    assign ex_ready = (state_reg == ST_IDLE);
    assign size     = ex_funct3[1:0];

    // Per-lane store data replication and byte strobes for the incoming store.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi % 4);
        assign st_wdata[gi*8 +: 8] = (size == 2'b00) ? ex_store_data[7:0] :
                                     (size == 2'b01) ? ex_store_data[(gi%2)*8 +: 8] :
                                                       ex_store_data[gi*8 +: 8];
        assign st_wstrb[gi] = (size == 2'b00) ? (ex_result[1:0] == LANE) :
                              (size == 2'b01) ? (ex_result[1] == LANE[1]) :
                                                1'b1;
    end

    // Decode the offered instruction: width legality, alignment and timeout condition.
    always_comb begin
        accept        = ex_valid && (state_reg == ST_IDLE);
        is_mem        = ex_is_load || ex_is_store;
        illegal_width = ex_is_load ? ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11))
                                   : (ex_funct3 > 3'b010);
        misaligned    = ((size == 2'b01) && ex_result[0]) ||
                        ((size == 2'b10) && (ex_result[1:0] != 2'b00));
        mem_start     = accept && is_mem && !illegal_width && !misaligned;
        mem_fault     = accept && is_mem && (illegal_width || misaligned);
        req_timeout   = (state_reg == ST_REQ) && !mem_ack && (TIMEOUT != 0) &&
                        (timer_reg == CNT_LAST);
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_byte = mem_rdata[{req_off_reg, 3'b000} +: 8];
        ld_half = req_off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (req_funct3_reg[1:0])
            2'b00:   ld_data = {{(DATA_WIDTH-8){~req_funct3_reg[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{(DATA_WIDTH-16){~req_funct3_reg[2] & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state logic; an ack in the last allowed cycle beats the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_next = req_load_reg ? ST_WB : ST_IDLE;
                end else if (req_timeout) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered memory port, writeback port, fault pulse and in-flight context.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wstrb      <= '0;
            mem_wdata      <= '0;
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            fault_valid    <= 1'b0;
            fault_code     <= 2'b00;
            req_load_reg   <= 1'b0;
            req_funct3_reg <= 3'b000;
            req_off_reg    <= 2'b00;
            req_rd_reg     <= '0;
            timer_reg      <= '0;
        end else begin
            rf_wen      <= 1'b0;
            fault_valid <= 1'b0;

            if (accept && !is_mem) begin
                rf_wen   <= (ex_rd != '0);
                rf_waddr <= ex_rd;
                rf_wdata <= ex_result;
            end

            if (mem_fault) begin
                fault_valid <= 1'b1;
                fault_code  <= illegal_width ? FAULT_ILLEGAL : FAULT_MISALIGN;
            end

            if (mem_start) begin
                mem_req        <= 1'b1;
                mem_we         <= ex_is_store;
                mem_addr       <= {ex_result[DATA_WIDTH-1:2], 2'b00};
                mem_wstrb      <= ex_is_store ? st_wstrb : '0;
                mem_wdata      <= ex_is_store ? st_wdata : '0;
                req_load_reg   <= ex_is_load;
                req_funct3_reg <= ex_funct3;
                req_off_reg    <= ex_result[1:0];
                req_rd_reg     <= ex_rd;
                timer_reg      <= '0;
            end

            if (state_reg == ST_REQ) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (req_load_reg) begin
                        // Write lands during WB, one cycle after the ack.
                        rf_wen   <= (req_rd_reg != '0);
                        rf_waddr <= req_rd_reg;
                        rf_wdata <= ld_data;
                    end
                end else if (req_timeout) begin
                    mem_req     <= 1'b0;
                    fault_valid <= 1'b1;
                    fault_code  <= FAULT_TIMEOUT;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback: directed cases plus randomized
// instruction mix, each outcome predicted by a transaction-level model.
module tb_lsu_writeback;

    localparam int TO = 4;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fault_valid;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fails  = 0;

    lsu_writeback #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .TIMEOUT   (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_funct3    (ex_funct3),
        .ex_result    (ex_result),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fault_valid  (fault_valid),
        .fault_code   (fault_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fault code predicted for an instruction: 0 none, 1 misaligned, 3 illegal width.
    function automatic logic [1:0] model_fault(input logic ld, input logic st,
                                               input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = int'(f3) % 4;
        if (!ld && !st) return 2'd0;
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd3;
        if (st && f3 > 3'd2) return 2'd3;
        if (sz == 1 && (a % 2) != 0) return 2'd1;
        if (sz == 2 && (a % 4) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int unsigned off;
        logic [31:0] v;
        off = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return (d & 32'hFF) * 32'h0101_0101;
            3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Offer one instruction at a negedge while the stage is idle and follow it to completion.
    task automatic run_instr(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                             input int ack_dly, input logic [31:0] rdata);
        logic [1:0]  exp_fault;
        logic [31:0] exp_addr;
        exp_fault = model_fault(ld, st, f3, res);
        exp_addr  = res & 32'hFFFF_FFFC;
        check_eq("ready_before", ex_ready, 1);
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
        mem_ack       = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
        @(negedge clock);
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        ex_result   = $urandom;
        ex_rd       = 5'($urandom);
        mem_ack     = 1'b0;
        if (!ld && !st) begin
            check_eq("alu_wen", rf_wen, (rd != 5'd0));
            if (rd != 5'd0) begin
                check_eq("alu_waddr", rf_waddr, rd);
                check_eq("alu_wdata", rf_wdata, res);
            end
            check_eq("alu_nofault", fault_valid, 0);
            check_eq("alu_noreq", mem_req, 0);
            check_eq("alu_ready", ex_ready, 1);
        end else if (exp_fault != 2'd0) begin
            check_eq("flt_valid", fault_valid, 1);
            check_eq("flt_code", fault_code, exp_fault);
            check_eq("flt_noreq", mem_req, 0);
            check_eq("flt_nowen", rf_wen, 0);
            check_eq("flt_ready", ex_ready, 1);
        end else begin
            check_eq("req_up", mem_req, 1);
            check_eq("req_we", mem_we, st);
            check_eq("req_addr", mem_addr, exp_addr);
            check_eq("req_strb", mem_wstrb, st ? model_strb(f3, res) : 4'h0);
            if (st) check_eq("req_wdata", mem_wdata, model_wdata(f3, sd));
            for (int c = 0; c < TO; c++) begin
                check_eq("req_hold", mem_req, 1);
                check_eq("req_addr_hold", mem_addr, exp_addr);
                check_eq("req_busy", ex_ready, 0);
                check_eq("req_nowen", rf_wen, 0);
                if (c == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clock);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (c == ack_dly) break;
            end
            check_eq("req_drop", mem_req, 0);
            if (ack_dly >= TO) begin
                check_eq("to_valid", fault_valid, 1);
                check_eq("to_code", fault_code, 2'd2);
                check_eq("to_nowen", rf_wen, 0);
                check_eq("to_ready", ex_ready, 1);
            end else if (ld) begin
                check_eq("ld_nofault", fault_valid, 0);
                check_eq("ld_wen", rf_wen, (rd != 5'd0));
                if (rd != 5'd0) begin
                    check_eq("ld_waddr", rf_waddr, rd);
                    check_eq("ld_wdata", rf_wdata, model_load(f3, res, rdata));
                end
                check_eq("ld_wb_busy", ex_ready, 0);
                @(negedge clock);
                check_eq("ld_wen_pulse", rf_wen, 0);
                check_eq("ld_ready", ex_ready, 1);
            end else begin
                check_eq("st_nowen", rf_wen, 0);
                check_eq("st_nofault", fault_valid, 0);
                check_eq("st_ready", ex_ready, 1);
            end
        end
        $display("txn ld=%0b st=%0b f3=%0d addr=%08h rd=%0d ack_dly=%0d", ld, st, f3, res, rd, ack_dly);
    endtask

    // Non-memory instructions offered on consecutive cycles.
    task automatic run_burst(input int n);
        logic [4:0]  prev_rd;
        logic [31:0] prev_res;
        prev_rd  = 5'd0;
        prev_res = 32'd0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                check_eq("burst_wen", rf_wen, (prev_rd != 5'd0));
                if (prev_rd != 5'd0) begin
                    check_eq("burst_waddr", rf_waddr, prev_rd);
                    check_eq("burst_wdata", rf_wdata, prev_res);
                end
            end
            check_eq("burst_ready", ex_ready, 1);
            if (i < n) begin
                prev_rd       = 5'($urandom);
                prev_res      = $urandom;
                ex_valid      = 1'b1;
                ex_is_load    = 1'b0;
                ex_is_store   = 1'b0;
                ex_funct3     = 3'($urandom);
                ex_rd         = prev_rd;
                ex_result     = prev_res;
            end else begin
                ex_valid = 1'b0;
            end
            @(negedge clock);
        end
        $display("txn burst of %0d back-to-back ALU results", n);
    endtask

    task automatic run_reset_in_req();
        check_eq("rst_ready_before", ex_ready, 1);
        ex_valid    = 1'b1;
        ex_is_load  = 1'b1;
        ex_is_store = 1'b0;
        ex_funct3   = 3'd2;
        ex_result   = 32'h0000_0040;
        ex_rd       = 5'd9;
        @(negedge clock);
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        check_eq("rst_req_up", mem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_req_low", mem_req, 0);
        check_eq("rst_nowen", rf_wen, 0);
        check_eq("rst_nofault", fault_valid, 0);
        check_eq("rst_ready", ex_ready, 1);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        mem_ack = 1'b0;
        check_eq("rst_stray_ack_wen", rf_wen, 0);
        check_eq("rst_stray_ack_req", mem_req, 0);
        $display("txn reset during outstanding load");
    endtask

    initial begin
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] res;
        int          kind;

        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_is_load    = 1'b0;
        ex_is_store   = 1'b0;
        ex_funct3     = 3'd0;
        ex_result     = 32'd0;
        ex_store_data = 32'd0;
        ex_rd         = 5'd0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;
        repeat (3) @(negedge clock);
        check_eq("reset_ready", ex_ready, 1);
        check_eq("reset_req", mem_req, 0);
        check_eq("reset_we", mem_we, 0);
        check_eq("reset_addr", mem_addr, 0);
        check_eq("reset_strb", mem_wstrb, 0);
        check_eq("reset_wdata", mem_wdata, 0);
        check_eq("reset_wen", rf_wen, 0);
        check_eq("reset_waddr", rf_waddr, 0);
        check_eq("reset_rfdata", rf_wdata, 0);
        check_eq("reset_fault", fault_valid, 0);
        check_eq("reset_code", fault_code, 0);
        reset = 1'b0;
        @(negedge clock);

        // ADD rd=5
        run_instr(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0);
        // LB 0x103, ack after 2 waiting cycles
        run_instr(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h80FF_0000);
        // SH 0x2
        run_instr(1'b0, 1'b1, 3'd1, 32'h0000_0002, 32'hABCD_1234, 5'd3, 1, 32'd0);
        // LW 0x6 misaligned
        run_instr(1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'd0, 5'd4, 0, 32'd0);
        // LW never acked
        run_instr(1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'd0, 5'd4, TO + 3, 32'd0);
        // LW acked in the last allowed cycle
        run_instr(1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'd0, 5'd6, TO - 1, 32'h1357_9BDF);
        // Load to x0
        run_instr(1'b1, 1'b0, 3'd4, 32'h0000_0031, 32'd0, 5'd0, 0, 32'h0000_AA00);
        // Illegal widths
        run_instr(1'b1, 1'b0, 3'd3, 32'h0000_0040, 32'd0, 5'd2, 0, 32'd0);
        run_instr(1'b0, 1'b1, 3'd4, 32'h0000_0040, 32'd0, 5'd2, 0, 32'd0);
        // LHU upper half, LH sign
        run_instr(1'b1, 1'b0, 3'd5, 32'h0000_0052, 32'd0, 5'd8, 0, 32'h9ABC_0000);
        run_instr(1'b1, 1'b0, 3'd1, 32'h0000_0052, 32'd0, 5'd8, 1, 32'h9ABC_0000);

        run_burst(8);
        run_reset_in_req();

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            ld   = (kind == 1);
            st   = (kind == 2);
            if ($urandom_range(0, 3) == 0) begin
                f3 = 3'($urandom);
            end else if (ld) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            res = $urandom;
            if ($urandom_range(0, 1) == 0) res = res & 32'hFFFF_FFFC;
            run_instr(ld, st, f3, res, $urandom, 5'($urandom), $urandom_range(0, TO + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
